fifo_ptr_sync: RTL
==================

# fifo_ptr_sync

Pointer-synchronisation and flag stage that consumes the Gray-coded pointer produced by the opposite-domain `pointer` block of the FIFO. It clocks the remote Gray pointer through a multi-flop synchroniser into the local domain and converts it back to binary. It then compares it against the local binary pointer to generate level, empty/full and a threshold flag. One instance sits on the read side (producing `empty`) and one on the write side (producing `full`).

## Interface

- `ptr_w`, 3: address width; FIFO depth = 2^ptr_w; all pointers are ptr_w+1 bits (MSB = lap bit).
- `SYNC_STAGES`, 2: synchroniser flops; legal range 2..4.
- `RD_SIDE`, 1: 1 = read-domain instance (remote = write pointer); 0 = write-domain instance (remote = read pointer).
- `THRESH`, 1: almost-empty level (read side) or almost-full margin (write side); legal range 0..2^ptr_w.

- `clk`, input, 1: local-domain clock; sole clock of the block.
- `rst`, input, 1: synchronous, active-high reset.
- `rmt_ptr_g`, input, ptr_w+1: remote-domain Gray pointer; asynchronous to `clk`.
- `lcl_ptr_b`, input, ptr_w+1: local binary pointer; registered in `clk` domain.
- `rmt_ptr_b`, output, ptr_w+1: synchronised remote pointer in binary; registered.
- `level`, output, ptr_w+1: occupancy as seen from this domain, range 0..2^ptr_w.
- `empty`, output, 1: level == 0; meaningful when RD_SIDE=1, tied 0 otherwise.
- `full`, output, 1: level == 2^ptr_w; meaningful when RD_SIDE=0, tied 0 otherwise.
- `almost`, output, 1: RD_SIDE=1: level <= THRESH; RD_SIDE=0: level >= 2^ptr_w - THRESH.
- `sync_err`, output, 1: sticky Gray-step violation flag (see Configuration).

## Operation

- Synchroniser: shift chain `sync[0..SYNC_STAGES-1]`. Each edge: sync[0] <= rmt_ptr_g and sync[k] <= sync[k-1]. No logic between stages.
- Gray→binary: b[ptr_w] = g[ptr_w]; b[i] = g[i] ^ b[i+1] for i = ptr_w-1 down to 0. Applied to the last stage, then registered into `rmt_ptr_b`.
- Level, modulo 2^(ptr_w+1), unsigned:
  - RD_SIDE=1: rmt_ptr_b − lcl_ptr_b.
  - RD_SIDE=0: lcl_ptr_b − rmt_ptr_b.
- Flags are combinational from registered `rmt_ptr_b` and registered `lcl_ptr_b`. There is no combinational path from `rmt_ptr_g`.
- Wrap-around: equal low ptr_w bits with differing MSB gives level = 2^ptr_w (full). Fully equal pointers give level 0 (empty). Pointer roll from 2^(ptr_w+1)−1 to 0 needs no special case because the subtraction is modulo.
- Flags are conservative by construction. Remote pointer staleness can only make empty/full assert early or deassert late, never the reverse.
- Level > 2^ptr_w is impossible in correct operation. If it occurs it is reported as-is, and `full` follows its equality definition.

## Timing

- Reset (rst high at edge):
  - All sync stages and `rmt_ptr_b` = 0.
  - With lcl_ptr_b = 0: level = 0; empty = 1 (RD_SIDE=1); full = 0; almost = 1 (RD_SIDE=1, any THRESH) or 0 (RD_SIDE=0, THRESH < 2^ptr_w).
  - `sync_err` = 0.
- Latency: a `rmt_ptr_g` change sampled at edge N appears on `rmt_ptr_b` after edge N+SYNC_STAGES, i.e. SYNC_STAGES+1 edges total.
- A `lcl_ptr_b` change affects level and flags in the same cycle (0 latency).
- Simultaneous local and remote change: the local change takes effect immediately; the remote change takes effect after SYNC_STAGES+1 edges.
- Reset mid-operation: reset takes priority on the edge. The synchroniser is flushed to 0 and refills after release from the live `rmt_ptr_g` within SYNC_STAGES+1 edges. During refill the flags reflect pointer 0.

## Configuration

- `PTR_CHECK_EN`: when defined, the block compares the last two synchroniser stages each cycle. If they differ in more than one bit, `sync_err` sets on the next edge and holds until `rst`. When undefined, the checker is not compiled and `sync_err` is tied to 0.

## Test plan

- Reset, RD_SIDE=1, ptr_w=3, lcl_ptr_b=0, rmt_ptr_g=0 -> empty=1, full=0, level=0, rmt_ptr_b=0, sync_err=0.
- Latency: set rmt_ptr_g from 0000 to 0001 (binary 1) at edge 0, SYNC_STAGES=2 -> rmt_ptr_b=1 and empty=0 first visible after edge 3; level=1, almost=1 (THRESH=1).
- Full and wrap, RD_SIDE=0: lcl_ptr_b=1000 (8), remote binary 0 -> level=8, full=1. Remote binary then advances to 1 (Gray 0001) -> full=0, level=7, almost=1, three edges later.
- Lap wrap: step both pointers through 15→0 one Gray step per cycle; remote binary trails local by 2 -> level stays 2 (RD_SIDE=0), with no full/empty glitch across the roll.
- With PTR_CHECK_EN: drive rmt_ptr_g 0000→0011 in one cycle -> sync_err=1 within SYNC_STAGES+1 edges and held until rst. Without PTR_CHECK_EN, the same stimulus -> sync_err stays 0.
- Reset mid-run: level=5, assert rst for 1 cycle with rmt_ptr_g held at 5 (Gray 0111) and lcl_ptr_b=0 -> rmt_ptr_b=0, empty=1 after the reset edge; rmt_ptr_b=5, level=5 three edges after release.

Source files
------------

// File: rtl/fifo_ptr_sync_if.sv
// ---------------------------------------------------------------------------
// fifo_ptr_sync_if
// Groups the pointer inputs and the level/flag outputs of one FIFO
// pointer-synchronisation stage.
//   master : drives rmt_ptr_g / lcl_ptr_b and observes the results
//   slave  : the fifo_ptr_sync block itself
// Signals:
//   rmt_ptr_g  remote-domain Gray pointer (async to the local clock)
//   lcl_ptr_b  local binary pointer (registered in the local domain)
//   rmt_ptr_b  synchronised remote pointer, binary, registered
//   level      occupancy seen from this domain (0..2^ptr_w)
//   empty      read-side empty flag
//   full       write-side full flag
//   almost     almost-empty (read side) / almost-full (write side)
//   sync_err   sticky Gray-step violation flag
// ---------------------------------------------------------------------------
interface fifo_ptr_sync_if #(
  parameter int ptr_w = 3
);
  logic [ptr_w:0] rmt_ptr_g;
  logic [ptr_w:0] lcl_ptr_b;
  logic [ptr_w:0] rmt_ptr_b;
  logic [ptr_w:0] level;
  logic           empty;
  logic           full;
  logic           almost;
  logic           sync_err;

  modport master (
    output rmt_ptr_g, lcl_ptr_b,
    input  rmt_ptr_b, level, empty, full, almost, sync_err
  );

  modport slave (
    input  rmt_ptr_g, lcl_ptr_b,
    output rmt_ptr_b, level, empty, full, almost, sync_err
  );
endinterface

// File: rtl/fifo_ptr_sync.sv
// ---------------------------------------------------------------------------
// fifo_ptr_sync
// Brings the opposite domain's Gray pointer into the local clock domain
// through a plain flop chain, converts it to binary, registers it, and
// derives occupancy and flags against the local binary pointer.
// One instance per FIFO side: RD_SIDE=1 yields empty, RD_SIDE=0 yields full.
//
// Ports:
//   clk  local-domain clock (sole clock)
//   rst  synchronous, active-high reset
//   bus  fifo_ptr_sync_if.slave (rmt_ptr_g, lcl_ptr_b in;
//        rmt_ptr_b, level, empty, full, almost, sync_err out)
//
// Parameters:
//   ptr_w        address width, pointers are ptr_w+1 bits (MSB = lap bit)
//   SYNC_STAGES  synchroniser depth, 2..4
//   RD_SIDE      1 = read domain (remote = write ptr), 0 = write domain
//   THRESH       almost-empty level / almost-full margin, 0..2^ptr_w
//
// Optional build macro:
//   PTR_CHECK_EN  enables the Gray-step checker driving sync_err;
//                 when undefined sync_err is tied to 0.
// ---------------------------------------------------------------------------
module fifo_ptr_sync #(
  parameter int ptr_w       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int RD_SIDE     = 1,
  parameter int THRESH      = 1
) (
  input  logic            clk,
  input  logic            rst,
  fifo_ptr_sync_if.slave  bus
);

  localparam logic [ptr_w:0] DEPTH  = (ptr_w+1)'(1 << ptr_w);
  localparam logic [ptr_w:0] THR    = (ptr_w+1)'(THRESH);
  localparam logic [ptr_w:0] AF_LVL = DEPTH - THR;

  function automatic logic [ptr_w:0] gray2bin(input logic [ptr_w:0] g);
    logic [ptr_w:0] b;
    b[ptr_w] = g[ptr_w];
    for (int i = ptr_w - 1; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

  logic [ptr_w:0] sync [SYNC_STAGES];
  logic [ptr_w:0] rmt_bin;
  logic [ptr_w:0] level;

  // Synchroniser chain: no logic between stages so each flop has a full
  // cycle to resolve metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync[k] <= '0;
      end
    end else begin
      sync[0] <= bus.rmt_ptr_g;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync[k] <= sync[k-1];
      end
    end
  end

  // Gray-to-binary on the settled last stage, then registered so the
  // flags never see a combinational path from the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      rmt_bin <= '0;
    end else begin
      rmt_bin <= gray2bin(sync[SYNC_STAGES-1]);
    end
  end

  assign bus.rmt_ptr_b = rmt_bin;

  // Level and flags: modulo subtraction handles the pointer roll, and the
  // lap bit distinguishes full (2^ptr_w) from empty (0).
  generate
    if (RD_SIDE != 0) begin : g_rd
      assign level      = rmt_bin - bus.lcl_ptr_b;
      assign bus.empty  = (level == '0);
      assign bus.full   = 1'b0;
      assign bus.almost = (level <= THR);
    end else begin : g_wr
      assign level      = bus.lcl_ptr_b - rmt_bin;
      assign bus.empty  = 1'b0;
      assign bus.full   = (level == DEPTH);
      assign bus.almost = (level >= AF_LVL);
    end
  endgenerate

  assign bus.level = level;

`ifdef PTR_CHECK_EN
  localparam logic [ptr_w:0] ONE = (ptr_w+1)'(1);

  logic [ptr_w:0] step;
  logic           multi_bit;
  logic           sync_err_r;

  // A legal Gray advance flips at most one bit between consecutive
  // samples; x & (x-1) is non-zero only when more than one bit is set.
  assign step      = sync[SYNC_STAGES-1] ^ sync[SYNC_STAGES-2];
  assign multi_bit = ((step & (step - ONE)) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err_r <= 1'b0;
    end else if (multi_bit) begin
      sync_err_r <= 1'b1;
    end
  end

  assign bus.sync_err = sync_err_r;
`else
  assign bus.sync_err = 1'b0;
`endif

endmodule
